// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-master SRAM port arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_WD = 8;
  localparam int DEF_DATA_WD = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    ACK
  } arb_state_t;

  typedef logic mst_idx_t;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-request arbiter: round-robin with last-grant pointer, or fixed m0 priority
// when SRAM_ARB_FIXED_PRIO_EN is defined. `hold` withdraws the grant for one cycle.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] pick,
  output logic [1:0] gnt
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = 2'b00;
    if (req[0])      pick = 2'b01;
    else if (req[1]) pick = 2'b10;
  end
`else
  mst_idx_t last;

  // On contention, grant the master that was not served last.
  always_comb begin
    pick = req;
    if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
`endif

  assign gnt = hold ? 2'b00 : pick;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 1rw1r SRAM between two Wishbone-classic masters: writes on port 0, reads on port 1.
// Build option SRAM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DATA_WD = DEF_DATA_WD
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_i,
  input  logic                 m0_wb_cyc_i,
  input  logic                 m0_wb_stb_i,
  input  logic                 m0_wb_we_i,
  input  logic [ADDR_WD-1:0]   m0_wb_adr_i,
  input  logic [DATA_WD/8-1:0] m0_wb_sel_i,
  input  logic [DATA_WD-1:0]   m0_wb_dat_i,
  output logic [DATA_WD-1:0]   m0_wb_dat_o,
  output logic                 m0_wb_ack_o,
  input  logic                 m1_wb_cyc_i,
  input  logic                 m1_wb_stb_i,
  input  logic                 m1_wb_we_i,
  input  logic [ADDR_WD-1:0]   m1_wb_adr_i,
  input  logic [DATA_WD/8-1:0] m1_wb_sel_i,
  input  logic [DATA_WD-1:0]   m1_wb_dat_i,
  output logic [DATA_WD-1:0]   m1_wb_dat_o,
  output logic                 m1_wb_ack_o,
  output logic                 sram_csb0,
  output logic                 sram_web0,
  output logic [DATA_WD/8-1:0] sram_wmask0,
  output logic [ADDR_WD-1:0]   sram_addr0,
  output logic [DATA_WD-1:0]   sram_din0,
  output logic                 sram_csb1,
  output logic [ADDR_WD-1:0]   sram_addr1,
  input  logic [DATA_WD-1:0]   sram_dout1
);

  localparam int SEL_WD = DATA_WD / 8;

  logic [1:0]         cyc, stb, we, ack;
  logic [ADDR_WD-1:0] adr  [2];
  logic [SEL_WD-1:0]  sel  [2];
  logic [DATA_WD-1:0] wdat [2];
  logic [DATA_WD-1:0] rdat [2];

  assign cyc     = {m1_wb_cyc_i, m0_wb_cyc_i};
  assign stb     = {m1_wb_stb_i, m0_wb_stb_i};
  assign we      = {m1_wb_we_i,  m0_wb_we_i};
  assign adr[0]  = m0_wb_adr_i;
  assign adr[1]  = m1_wb_adr_i;
  assign sel[0]  = m0_wb_sel_i;
  assign sel[1]  = m1_wb_sel_i;
  assign wdat[0] = m0_wb_dat_i;
  assign wdat[1] = m1_wb_dat_i;

  arb_state_t st     [2];
  arb_state_t st_nxt [2];
  logic [1:0] wr_req, rd_req, wr_pick, wr_gnt, rd_pick, rd_gnt;
  mst_idx_t   wr_idx, rd_idx;
  logic       hazard;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_req[k] = (st[k] == IDLE) && cyc[k] && stb[k] &&  we[k];
      rd_req[k] = (st[k] == IDLE) && cyc[k] && stb[k] && !we[k];
    end
  end

  assign wr_idx = wr_pick[1];
  assign rd_idx = rd_pick[1];

  // A read racing a write to the same word from the other master waits a cycle.
  assign hazard = (|wr_pick) && (|rd_pick) && (adr[wr_idx] == adr[rd_idx]);

  sram_arb_rr2 u_wr_arb (
    .clk  (wb_clk_i),
    .rst  (rst_i),
    .req  (wr_req),
    .hold (1'b0),
    .pick (wr_pick),
    .gnt  (wr_gnt)
  );

  sram_arb_rr2 u_rd_arb (
    .clk  (wb_clk_i),
    .rst  (rst_i),
    .req  (rd_req),
    .hold (hazard),
    .pick (rd_pick),
    .gnt  (rd_gnt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++) st[k] <= IDLE;
    end else begin
      for (int k = 0; k < 2; k++) st[k] <= st_nxt[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_nxt[k] = st[k];
      case (st[k])
        IDLE: begin
          if (wr_gnt[k])      st_nxt[k] = WR_ISSUE;
          else if (rd_gnt[k]) st_nxt[k] = RD_ISSUE;
        end
        WR_ISSUE: st_nxt[k] = ACK;
        RD_ISSUE: st_nxt[k] = RD_WAIT;
        RD_WAIT:  st_nxt[k] = ACK;
        ACK:      st_nxt[k] = IDLE;
        default:  st_nxt[k] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) ack[k] = (st[k] == ACK);
  end

  assign m0_wb_ack_o = ack[0];
  assign m1_wb_ack_o = ack[1];

  // SRAM command is registered so the macro sees it in the ISSUE cycle.
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
    end else begin
      sram_csb0 <= ~|wr_gnt;
      sram_web0 <= ~|wr_gnt;
      if (|wr_gnt) begin
        sram_wmask0 <= sel[wr_idx];
        sram_addr0  <= adr[wr_idx];
        sram_din0   <= wdat[wr_idx];
      end
      sram_csb1 <= ~|rd_gnt;
      if (|rd_gnt) sram_addr1 <= adr[rd_idx];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++) rdat[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (st[k] == RD_WAIT) rdat[k] <= sram_dout1;
      end
    end
  end

  assign m0_wb_dat_o = rdat[0];
  assign m1_wb_dat_o = rdat[1];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1rw1r SRAM and per-master response queues.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc_i, stb_i, we_i;
  logic [7:0]  adr_i [2];
  logic [3:0]  sel_i [2];
  logic [31:0] dat_i [2];
  logic [31:0] dat0, dat1;
  logic        ack0, ack1;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout1;

  sram_port_arbiter dut (
    .wb_clk_i    (clk),
    .rst_i       (rst),
    .m0_wb_cyc_i (cyc_i[0]),
    .m0_wb_stb_i (stb_i[0]),
    .m0_wb_we_i  (we_i[0]),
    .m0_wb_adr_i (adr_i[0]),
    .m0_wb_sel_i (sel_i[0]),
    .m0_wb_dat_i (dat_i[0]),
    .m0_wb_dat_o (dat0),
    .m0_wb_ack_o (ack0),
    .m1_wb_cyc_i (cyc_i[1]),
    .m1_wb_stb_i (stb_i[1]),
    .m1_wb_we_i  (we_i[1]),
    .m1_wb_adr_i (adr_i[1]),
    .m1_wb_sel_i (sel_i[1]),
    .m1_wb_dat_i (dat_i[1]),
    .m1_wb_dat_o (dat1),
    .m1_wb_ack_o (ack1),
    .sram_csb0   (csb0),
    .sram_web0   (web0),
    .sram_wmask0 (wmask0),
    .sram_addr0  (addr0),
    .sram_din0   (din0),
    .sram_csb1   (csb1),
    .sram_addr1  (addr1),
    .sram_dout1  (dout1)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural SRAM macro: one-cycle registered read, masked write.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    dout1 = '0;
  end
  always @(posedge clk) begin
    if (!csb0 && !web0)
      for (int b = 0; b < 4; b++)
        if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
    if (!csb1) dout1 <= mem[addr1];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] d;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check_resp(input int k, input exp_t e, input logic [31:0] d);
    if (e.lat >= 0) chk($sformatf("m%0d_latency", k), cyc_n - e.t0, e.lat);
    if (e.rd)       chk($sformatf("m%0d_rdata", k), d, e.d);
  endtask

  task automatic unexpected_ack(input int k);
    n_checks++;
    n_err++;
    $display("FAIL m%0d_unexpected_ack: got ack=1 expected no pending request (t=%0t)", k, $time);
  endtask

  // Monitor: every ack pops one expected response for that master.
  always @(negedge clk) begin
    exp_t e;
    if (ack0) begin
      if (q0.size() == 0) unexpected_ack(0);
      else begin e = q0.pop_front(); check_resp(0, e, dat0); end
    end
    if (ack1) begin
      if (q1.size() == 0) unexpected_ack(1);
      else begin e = q1.pop_front(); check_resp(1, e, dat1); end
    end
  end

  logic [7:0] wlog[$];
  always @(negedge clk) if (!csb0 && !web0) wlog.push_back(addr0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one transfer from the current cycle (cycle 0) and returns at the start of the
  // cycle after the ack, with the request dropped.
  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_d, input int lat);
    exp_t e;
    bit   got;
    e.rd = !w; e.d = exp_d; e.lat = lat; e.t0 = cyc_n;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    cyc_i[k] = 1'b1; stb_i[k] = 1'b1; we_i[k] = w;
    adr_i[k] = a; dat_i[k] = d; sel_i[k] = s;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (k == 0) ? ack0 : ack1;
    end
    if (!got) chk($sformatf("m%0d_ack_timeout", k), 32'd0, 32'd1);
    step();
    cyc_i[k] = 1'b0; stb_i[k] = 1'b0; we_i[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc_i = '0; stb_i = '0; we_i = '0;
    for (int k = 0; k < 2; k++) begin adr_i[k] = '0; sel_i[k] = '0; dat_i[k] = '0; end
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_csb0", csb0, 1); chk("rst_web0", web0, 1); chk("rst_csb1", csb1, 1);
    chk("rst_wmask0", wmask0, 0); chk("rst_addr0", addr0, 0); chk("rst_din0", din0, 0);
    chk("rst_addr1", addr1, 0); chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_dat0", dat0, 0); chk("rst_dat1", dat1, 0);
    step();

    // Single write then readback, with port-0/port-1 strobe timing.
    fork
      xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 2);
      begin
        @(negedge clk); chk("wr_c0_csb0", csb0, 1);
        @(negedge clk); chk("wr_c1_csb0", csb0, 0); chk("wr_c1_web0", web0, 0);
        chk("wr_c1_addr0", addr0, 8'h10); chk("wr_c1_din0", din0, 32'hDEADBEEF);
        chk("wr_c1_wmask0", wmask0, 4'hF);
        @(negedge clk); chk("wr_c2_csb0", csb0, 1);
      end
    join
    fork
      xfer(0, 0, 8'h10, 0, 4'hF, 32'hDEADBEEF, 3);
      begin
        @(negedge clk); chk("rd_c0_csb1", csb1, 1);
        @(negedge clk); chk("rd_c1_csb1", csb1, 0); chk("rd_c1_addr1", addr1, 8'h10);
        @(negedge clk); chk("rd_c2_csb1", csb1, 1);
      end
    join

    // Simultaneous writes after m0 was last served on port 0.
    wlog.delete();
    fork
`ifdef SRAM_ARB_FIXED_PRIO_EN
      xfer(0, 1, 8'h74, 32'h74, 4'hF, 0, 2);
      xfer(1, 1, 8'h75, 32'h75, 4'hF, 0, 3);
`else
      xfer(0, 1, 8'h74, 32'h74, 4'hF, 0, 3);
      xfer(1, 1, 8'h75, 32'h75, 4'hF, 0, 2);
`endif
    join
    chk("contend_n", wlog.size(), 2);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    if (wlog.size() == 2) begin chk("contend_1st", wlog[0], 8'h74); chk("contend_2nd", wlog[1], 8'h75); end
`else
    if (wlog.size() == 2) begin chk("contend_1st", wlog[0], 8'h75); chk("contend_2nd", wlog[1], 8'h74); end
`endif

    // Continuous writes from both masters must interleave on port 0.
    wlog.delete();
    fork
      for (int i = 0; i < 3; i++) xfer(0, 1, 8'h50 + 8'(i), 32'h500 + i, 4'hF, 0, -1);
      for (int i = 0; i < 3; i++) xfer(1, 1, 8'h60 + 8'(i), 32'h600 + i, 4'hF, 0, -1);
    join
    chk("stream_n", wlog.size(), 6);
    for (int i = 1; i < wlog.size(); i++)
      chk($sformatf("stream_alt%0d", i), {31'd0, wlog[i][5]}, {31'd0, ~wlog[i-1][5]});

    // Write and read of different words proceed in parallel.
    xfer(1, 1, 8'h21, 32'h12345678, 4'hF, 0, 2);
    fork
      xfer(0, 1, 8'h20, 32'hCAFEF00D, 4'hF, 0, 2);
      xfer(1, 0, 8'h21, 0, 4'hF, 32'h12345678, 3);
      begin
        @(negedge clk); @(negedge clk);
        chk("par_c1_csb0", csb0, 0); chk("par_c1_csb1", csb1, 0);
      end
    join

    // Same-word write and read from different masters: read slips one cycle.
    fork
      xfer(0, 1, 8'h30, 32'h11111111, 4'hF, 0, 2);
      xfer(1, 0, 8'h30, 0, 4'hF, 32'h11111111, 4);
      begin
        @(negedge clk); @(negedge clk);
        chk("haz_c1_csb0", csb0, 0); chk("haz_c1_csb1", csb1, 1);
        @(negedge clk);
        chk("haz_c2_csb1", csb1, 0); chk("haz_c2_addr1", addr1, 8'h30);
      end
    join

    // Partial and empty byte masks.
    xfer(0, 1, 8'h40, 32'h00000000, 4'hF, 0, 2);
    xfer(0, 1, 8'h40, 32'hAABBCCDD, 4'h3, 0, 2);
    xfer(0, 0, 8'h40, 0, 4'hF, 32'h0000CCDD, 3);
    xfer(1, 1, 8'h40, 32'hFFFFFFFF, 4'h0, 0, 2);
    xfer(1, 0, 8'h40, 0, 4'hF, 32'h0000CCDD, 3);

    // Reset while a read sits in RD_WAIT.
    cyc_i[0] = 1'b1; stb_i[0] = 1'b1; we_i[0] = 1'b0; adr_i[0] = 8'h10;
    step();
    step();
    rst = 1'b1;
    cyc_i[0] = 1'b0; stb_i[0] = 1'b0;
    @(negedge clk); chk("rstrd_c2_ack", ack0, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd_csb1", csb1, 1); chk("rstrd_dat0", dat0, 0); chk("rstrd_ack", ack0, 0);
    repeat (5) step();
    xfer(0, 0, 8'h10, 0, 4'hF, 32'hDEADBEEF, 3);

    repeat (5) step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

- Shares the 1rw1r 32x256 SRAM macro between two Wishbone-classic requesters.
  - m0 is the interconnect slave-0 path; m1 is reserved for an on-chip accelerator or DMA.
- All writes go to macro port 0 (RW) and all reads to port 1 (R), so a read from one master and a write from the other proceed in the same cycle.
- Sits between the interconnect/accelerator and the SRAM macro.
- Replaces the direct single-master SRAM Wishbone wrapper.

## Interface
- ADDR_WD, 8, SRAM word address width
- DATA_WD, 32, data width; byte lanes = DATA_WD/8
- wb_clk_i  in  1  system clock; also drives clk0/clk1 of the macro
- rst_i  in  1  synchronous, active-high reset
- mK_wb_cyc_i, mK_wb_stb_i, mK_wb_we_i  in  1 each  Wishbone request, K∈{0,1}
- mK_wb_adr_i  in  ADDR_WD  word address
- mK_wb_sel_i  in  DATA_WD/8  byte enables
- mK_wb_dat_i  in  DATA_WD  write data
- mK_wb_dat_o  out  DATA_WD  read data
- mK_wb_ack_o  out  1  acknowledge
- sram_csb0, sram_web0  out  1 each  port 0 select / write-enable (active low)
- sram_wmask0  out  DATA_WD/8  port 0 byte mask
- sram_addr0  out  ADDR_WD  port 0 address
- sram_din0  out  DATA_WD  port 0 write data
- sram_csb1  out  1  port 1 select (active low)
- sram_addr1  out  ADDR_WD  port 1 address
- sram_dout1  in  DATA_WD  port 1 read data

## Operation
- Request from master K = cyc&stb while its FSM is IDLE. Masters hold all request signals stable until ack (Wishbone classic).
- Per-master FSM: IDLE → WR_ISSUE → ACK → IDLE for writes; IDLE → RD_ISSUE → RD_WAIT → ACK → IDLE for reads.
- Two independent arbiters:
  - Write arbiter owns port 0; read arbiter owns port 1.
  - Each is 2-way round-robin with its own last-grant pointer.
  - Pointer updates only on a grant.
  - Reset pointer favours m0.
- Hazard: if the write grant and the read grant in the same cycle go to different masters with equal addresses, the read is not granted that cycle; the write proceeds. The read retries next cycle.
- A request that loses arbitration stays in IDLE and is re-evaluated every cycle.
- Port drive in ISSUE state (all registered):
  - Write: csb0=0, web0=0, wmask0=sel, addr0=adr, din0=dat_i.
  - Read: csb1=0, addr1=adr.
- sel=0 write: the write is issued with wmask0=0 and acked normally.
- Read data: sram_dout1 is captured into mK_wb_dat_o at the end of RD_WAIT and held until the next read by that master completes.
- ACK state: mK_wb_ack_o=1 for exactly one cycle. A new request is not accepted in the ACK cycle.
- Requests with cyc=0 or stb=0 are ignored. Dropping cyc mid-transaction does not abort the access; the ack is still produced.
- Reset values: csb0=1, web0=1, csb1=1; wmask0, addr0, din0, addr1 = 0; all acks = 0; all dat_o = 0; FSMs IDLE.
- Reset mid-operation abandons the in-flight access. A pending ack is never emitted.

## Timing
- Cycle 0: request sampled and granted.
- Cycle 1: SRAM command driven; the macro captures it at the end of cycle 1.
- Write: ack in cycle 2, so latency 2.
- Read: dout1 valid in cycle 2, registered at the end of cycle 2; ack and data in cycle 3, so latency 3.
- Idle outputs: csb0/csb1 high in every cycle without an ISSUE state on that port.
- Back-to-back: a master's next request is granted no earlier than the cycle after its ack. Peak rate per master is one write per 3 cycles and one read per 4 cycles.
- Simultaneous conflicting requests: round-robin alternates grants. Neither master waits more than one extra transaction per port.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN:
  - Defined: both arbiters use fixed priority, m0 always wins; pointers are not implemented.
  - Undefined: round-robin as above.
- The hazard rule is unchanged in both builds.

## Structure
- Package sram_arb_pkg holds:
  - FSM state enum (IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, ACK).
  - Default ADDR_WD/DATA_WD constants.
  - Master-index type.
- Sub-module sram_arb_rr2: 2-request arbiter with pointer and fixed-priority option. Instantiated once per SRAM port.

## Test plan
- m0 write adr 0x10, dat 0xDEADBEEF, sel 0xF, then read 0x10 → write ack at cycle 2; read ack at cycle 3 with 0xDEADBEEF; csb0 low only in cycle 1.
- m0 and m1 both write continuously to different addresses:
  - Default build → grants alternate m0, m1, m0 …
  - With SRAM_ARB_FIXED_PRIO_EN → m1 is granted only in cycles where m0 does not request.
- m0 write 0x20 and m1 read 0x21 in the same cycle → csb0 and csb1 both low in cycle 1; both complete with no added delay.
- m0 write 0x30 (0x11111111) and m1 read 0x30 in the same cycle → write goes first; the read is issued one cycle later and returns 0x11111111.
- sel=0x3 write of 0xAABBCCDD over 0x00000000 at 0x40 → readback 0x0000CCDD.
- rst_i asserted in RD_WAIT → no ack is ever produced; next cycle csb1=1 and dat_o=0; a fresh read after reset completes normally.
